// File: rtl/dmem_responder.sv
// Word-organised data-memory responder with a fixed multi-cycle access latency.
// Holds the pipeline with stall_o while a request is in flight and acks it once.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4,
  parameter int CNT_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [1:0]  dbg_state_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int              AW       = $clog2(DEPTH);
  localparam int              LOAD     = (LATENCY >= 2) ? (LATENCY - 2) : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD);
  localparam logic [29:0]     DEPTH_W  = 30'(DEPTH);
  localparam logic            DIRECT   = (LATENCY == 1);

  // Handshake: req_i is sampled only in IDLE; stall_o holds the MEM stage until
  // the RESP cycle, in which ack_o pulses exactly once for that request.

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             ack_q;
  logic             err_q;
  logic [31:0]      rdata_q;
  logic [31:0]      mem [DEPTH];

  logic             in_idle;
  logic             in_wait;
  logic             accept;
  logic             enter_resp;
  logic             acc_we;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic             acc_err;
  logic [AW-1:0]    mem_idx;

  assign in_idle = (state_q == S_IDLE);
  assign in_wait = (state_q == S_WAIT);
  assign accept  = in_idle & req_i;

  // A LATENCY=1 build completes straight from IDLE, so the live inputs are used
  // there; every other completion comes out of WAIT with the latched copy.
  assign enter_resp = (accept & DIRECT) | (in_wait & (cnt_q == '0));
  assign acc_we     = in_idle ? we_i    : we_q;
  assign acc_addr   = in_idle ? addr_i  : addr_q;
  assign acc_wdata  = in_idle ? wdata_i : wdata_q;

  // Full word index is compared so high addresses never alias onto low words.
  assign acc_err = (acc_addr[1:0] != 2'b00) | (acc_addr[31:2] >= DEPTH_W);
  assign mem_idx = acc_addr[AW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          if (DIRECT) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= enter_resp;
      err_q   <= enter_resp & acc_err;
      if (accept) begin
        we_q    <= we_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      if (enter_resp) begin
        rdata_q <= (acc_we | acc_err) ? 32'h0 : mem[mem_idx];
      end
    end
  end

  // Store contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk_i) begin
    if (enter_resp & acc_we & ~acc_err & ~rst_i) begin
      mem[mem_idx] <= acc_wdata;
    end
  end

  assign stall_o     = ~rst_i & (accept | in_wait);
  assign ack_o       = ack_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign dbg_state_o = state_q;

endmodule
